// File: rtl/fifo_state_reg.sv
// -----------------------------------------------------------------------------
// fifo_state_reg
//
// State and storage half of a FIFO. An external controller computes the next
// write pointer, read pointer and occupancy; this block registers them, feeds
// them back, holds the entry storage and presents the head entry show-ahead.
// A sticky error flag reports any next-state triple that is inconsistent.
// The flag only reports: the offending values are still loaded.
//
// Parameters
//   NUM_DATA  FIFO depth, a power of two, at least 2
//   DATA_BW   width of one entry
//
// Ports
//   clk           sole clock, rising edge
//   rst           synchronous, active-high reset
//   wr_data       entry stored on a push
//   reg_push      qualified push, already gated by not-full
//   next_wrptr    controller's next write pointer
//   next_rdptr    controller's next read pointer
//   next_numitem  controller's next occupancy (0..NUM_DATA)
//   wr_ptr        registered write pointer
//   rd_ptr        registered read pointer
//   num_item      registered occupancy
//   rd_data       entry at rd_ptr, no write-to-read bypass
//   err           sticky consistency error, cleared only by reset
// -----------------------------------------------------------------------------
module fifo_state_reg #(
  parameter int NUM_DATA = 4,
  parameter int DATA_BW  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BW-1:0]            wr_data,
  input  logic                          reg_push,
  input  logic [$clog2(NUM_DATA)-1:0]   next_wrptr,
  input  logic [$clog2(NUM_DATA)-1:0]   next_rdptr,
  input  logic [$clog2(NUM_DATA):0]     next_numitem,
  output logic [$clog2(NUM_DATA)-1:0]   wr_ptr,
  output logic [$clog2(NUM_DATA)-1:0]   rd_ptr,
  output logic [$clog2(NUM_DATA):0]     num_item,
  output logic [DATA_BW-1:0]            rd_data,
  output logic                          err
);

  localparam int ADDR_BW = $clog2(NUM_DATA);

  // Depth expressed at occupancy width so the overflow compare is same-width.
  localparam logic [ADDR_BW:0] NUM_DATA_W = (ADDR_BW + 1)'(NUM_DATA);

  logic [DATA_BW-1:0] mem [NUM_DATA];

  logic [ADDR_BW-1:0] ptr_span;
  logic               err_detect;

  // Consistency of the incoming next-state triple. The pointer difference
  // wraps naturally at ADDR_BW bits, so it equals the occupancy modulo the
  // depth; a full FIFO (occupancy NUM_DATA) has equal pointers.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the block leaves it unassigned and infers a latch.
    err_detect = 1'b0;
    ptr_span   = next_wrptr - next_rdptr;
    if (next_numitem > NUM_DATA_W) begin
      err_detect = 1'b1;
    end
    if (ptr_span != next_numitem[ADDR_BW-1:0]) begin
      err_detect = 1'b1;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values, including mem[wr_ptr] below using the
  // old wr_ptr while wr_ptr itself is being reloaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      num_item <= '0;
      err      <= 1'b0;
      // NOTE: storage is cleared on reset on purpose: rd_data is read
      // combinationally even when empty and must never show X after reset.
      for (int i = 0; i < NUM_DATA; i++) begin
        mem[i] <= '0;
      end
    end else begin
      wr_ptr   <= next_wrptr;
      rd_ptr   <= next_rdptr;
      num_item <= next_numitem;
      if (err_detect) begin
        err <= 1'b1;
      end
      if (reg_push) begin
        mem[wr_ptr] <= wr_data;
      end
    end
  end

  // Show-ahead head entry; a push to this slot appears only after the edge.
  assign rd_data = mem[rd_ptr];

endmodule

// File: tb/tb_fifo_state_reg.sv
// -----------------------------------------------------------------------------
// tb_fifo_state_reg
//
// Directed bench for fifo_state_reg at NUM_DATA=4, DATA_BW=8. A small
// controller in the bench produces the next_* inputs; a behavioural model of
// the FIFO contents and the consistency rule predicts every output, and a
// compare process checks the DUT against it on each falling edge. Literal
// expectations pin the model at key points of each scenario.
// -----------------------------------------------------------------------------
module tb_fifo_state_reg;

  localparam int ND = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wr_data;
  logic       reg_push;
  logic [1:0] next_wrptr;
  logic [1:0] next_rdptr;
  logic [2:0] next_numitem;
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] num_item;
  logic [7:0] rd_data;
  logic       err;

  int checks   = 0;
  int failures = 0;

  fifo_state_reg #(.NUM_DATA(ND), .DATA_BW(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_data      (wr_data),
    .reg_push     (reg_push),
    .next_wrptr   (next_wrptr),
    .next_rdptr   (next_rdptr),
    .next_numitem (next_numitem),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .num_item     (num_item),
    .rd_data      (rd_data),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: contents as a plain array, occupancy as an integer,
  // error as the spec's arithmetic rule on integers.
  // ---------------------------------------------------------------------------
  int   m_mem [ND];
  int   m_wr, m_rd, m_num;
  bit   m_err;
  bit   m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ND; i++) m_mem[i] = 0;
      m_wr = 0; m_rd = 0; m_num = 0; m_err = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (reg_push) m_mem[m_wr] = int'(wr_data);
      if (int'(next_numitem) > ND) m_err = 1'b1;
      if (((int'(next_wrptr) - int'(next_rdptr) + ND) % ND) != (int'(next_numitem) % ND))
        m_err = 1'b1;
      m_wr  = int'(next_wrptr);
      m_rd  = int'(next_rdptr);
      m_num = int'(next_numitem);
    end
  end

  // Compare process: outputs checked against the model every cycle after the
  // first reset edge, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("wr_ptr",   32'(wr_ptr),   32'(m_wr));
      check("rd_ptr",   32'(rd_ptr),   32'(m_rd));
      check("num_item", 32'(num_item), 32'(m_num));
      check("rd_data",  32'(rd_data),  32'(m_mem[m_rd]));
      check("err",      32'(err),      32'(m_err));
    end
  end

  // ---------------------------------------------------------------------------
  // Bench-side controller and drivers
  // ---------------------------------------------------------------------------
  logic [1:0] c_wr, c_rd;
  logic [2:0] c_num;

  // Drive one cycle of raw inputs; returns 1 time unit after the edge.
  task automatic drive(input logic r, input logic p, input logic [7:0] d,
                       input logic [1:0] nw, input logic [1:0] nr, input logic [2:0] nn);
    rst = r; reg_push = p; wr_data = d;
    next_wrptr = nw; next_rdptr = nr; next_numitem = nn;
    @(posedge clk);
    #1;
    if (r) begin
      c_wr = '0; c_rd = '0; c_num = '0;
    end else begin
      c_wr = nw; c_rd = nr; c_num = nn;
    end
  endtask

  task automatic do_reset(input logic p, input logic [7:0] d);
    drive(1'b1, p, d, 2'd3, 2'd2, 3'd1);
  endtask

  // Well-behaved controller operation: optional push and/or pop.
  task automatic op(input logic push, input logic pop, input logic [7:0] d);
    logic [1:0] nw, nr;
    logic [2:0] nn;
    nw = push ? c_wr + 2'd1 : c_wr;
    nr = pop  ? c_rd + 2'd1 : c_rd;
    nn = c_num + (push ? 3'd1 : 3'd0) - (pop ? 3'd1 : 3'd0);
    drive(1'b0, push, d, nw, nr, nn);
  endtask

  logic [7:0] fill_vals [4];
  logic [7:0] pop_exp   [4];

  initial begin
    rst = 1'b0; reg_push = 1'b0; wr_data = '0;
    next_wrptr = '0; next_rdptr = '0; next_numitem = '0;
    c_wr = '0; c_rd = '0; c_num = '0;
    fill_vals[0] = 8'h11; fill_vals[1] = 8'h22; fill_vals[2] = 8'h33; fill_vals[3] = 8'h44;
    pop_exp[0]   = 8'h22; pop_exp[1]   = 8'h33; pop_exp[2]   = 8'h44; pop_exp[3]   = 8'h11;
    @(negedge clk);

    // Reset state
    do_reset(1'b0, 8'h00);
    check("rst_wr_ptr",   32'(wr_ptr),   32'd0);
    check("rst_rd_ptr",   32'(rd_ptr),   32'd0);
    check("rst_num_item", 32'(num_item), 32'd0);
    check("rst_rd_data",  32'(rd_data),  32'h00);
    check("rst_err",      32'(err),      32'd0);

    // Single push
    op(1'b1, 1'b0, 8'hA5);
    check("push_rd_data",  32'(rd_data),  32'hA5);
    check("push_wr_ptr",   32'(wr_ptr),   32'd1);
    check("push_num_item", 32'(num_item), 32'd1);

    // Fill to full, then drain with pointer wrap
    do_reset(1'b0, 8'h00);
    for (int i = 0; i < 4; i++) op(1'b1, 1'b0, fill_vals[i]);
    check("full_num_item", 32'(num_item), 32'd4);
    check("full_wr_ptr",   32'(wr_ptr),   32'd0);
    check("full_rd_data",  32'(rd_data),  32'h11);
    for (int i = 0; i < 4; i++) begin
      op(1'b0, 1'b1, 8'h00);
      check("pop_rd_data", 32'(rd_data), 32'(pop_exp[i]));
    end
    check("empty_num_item", 32'(num_item), 32'd0);
    check("empty_rd_ptr",   32'(rd_ptr),   32'd0);
    check("fill_err",       32'(err),      32'd0);

    // Push into the empty slot at rd_ptr: visible only after the edge
    op(1'b1, 1'b0, 8'h77);
    check("nobypass_rd_data", 32'(rd_data), 32'h77);

    // Simultaneous push and pop
    do_reset(1'b0, 8'h00);
    op(1'b1, 1'b0, 8'h01);
    op(1'b1, 1'b0, 8'h02);
    op(1'b1, 1'b1, 8'h5A);
    check("pp_rd_data",  32'(rd_data),  32'h02);
    check("pp_num_item", 32'(num_item), 32'd2);
    check("pp_wr_ptr",   32'(wr_ptr),   32'd3);
    check("pp_err",      32'(err),      32'd0);
    op(1'b0, 1'b1, 8'h00);
    check("pp_entry2", 32'(rd_data), 32'h5A);

    // Overflow error: sticky, registers still load the bad occupancy
    drive(1'b0, 1'b0, 8'h00, c_wr, c_rd, 3'd5);
    check("ovf_err",      32'(err),      32'd1);
    check("ovf_num_item", 32'(num_item), 32'd5);
    drive(1'b0, 1'b0, 8'h00, c_wr, c_rd, 3'd1);
    check("ovf_sticky", 32'(err), 32'd1);
    do_reset(1'b0, 8'h00);
    check("ovf_cleared", 32'(err), 32'd0);

    // Pointer/occupancy mismatch error
    drive(1'b0, 1'b0, 8'h00, 2'd1, 2'd0, 3'd0);
    check("mis_err", 32'(err), 32'd1);
    do_reset(1'b0, 8'h00);
    // Full FIFO with equal pointers is consistent
    drive(1'b0, 1'b0, 8'h00, 2'd2, 2'd2, 3'd4);
    check("full_eq_ptr_err", 32'(err), 32'd0);

    // Reset mid-operation with a push on the same edge
    do_reset(1'b0, 8'h00);
    for (int i = 0; i < 3; i++) op(1'b1, 1'b0, 8'hC0 + 8'(i));
    check("mid_num_item", 32'(num_item), 32'd3);
    do_reset(1'b1, 8'hEE);
    check("mid_wr_ptr",   32'(wr_ptr),   32'd0);
    check("mid_num_zero", 32'(num_item), 32'd0);
    check("mid_rd_data",  32'(rd_data),  32'h00);
    op(1'b0, 1'b0, 8'h00);
    check("mid_hold_rd", 32'(rd_data), 32'h00);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
